sysctrl_multi: RTL and testbench

Parametrised system control block: a software-writable control register plus a multi-source system-reset sequencer. Any request starts a timed `sysrst` pulse; software reset or one of `NUM_CAUSES` hardware reset request lines can make the request. A cause/count register records why the last restart happened. Storage bits survive the system reset so software can pass error information across a restart. It sits on the I/O bus next to the other base peripherals and drives `sysrst` to the rest of the system.

---
 rtl/sysctrl_multi_if.sv | 15 +
 rtl/sysctrl_multi.sv | 121 ++++++++++++
 tb/tb_sysctrl_multi.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sysctrl_multi_if.sv
// sysctrl_multi_if: single-cycle register bus between a master and sysctrl_multi.
// ack follows stb combinationally; data_out is 0 unless a read is in progress.
interface sysctrl_multi_if;
    logic        stb;
    logic        we;
    logic        addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;

    modport master (output stb, output we, output addr, output data_in,
                    input  data_out, input ack);
    modport slave  (input  stb, input  we, input  addr, input  data_in,
                    output data_out, output ack);
endinterface

// File: rtl/sysctrl_multi.sv
// sysctrl_multi: software control register plus a multi-source system-reset
// sequencer. A request from software (SCR bit 0) or any rst_req line starts a
// registered sysrst pulse of RST_HOLD cycles followed by one settle cycle.
// CAUSE records which sources started the last sequence and a saturating count.
// Optional feature macro: SYSCTRL_RST_ON_POR_EN -- when defined, a sequence
// starts automatically after rst without touching CAUSE or the count.
module sysctrl_multi #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CAUSES = 2,
    parameter int RST_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sysctrl_multi_if.slave        bus,
    input  logic [NUM_CAUSES-1:0] rst_req,
    output logic                  sysrst
);
    localparam int CW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {IDLE, HOLD, SETTLE} state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic                  r_sysrst;
    logic [DATA_WIDTH-1:1] r_scr;
    logic [NUM_CAUSES:0]   r_cause;
    logic                  r_por;
    logic [7:0]            r_count;

    logic                  w_scr_wr, w_cause_wr, w_sw_req, w_req, w_start, w_busy;
    logic [31:0]           w_scr_rd, w_cause_rd;

    assign w_scr_wr   = bus.stb & bus.we & ~bus.addr;
    assign w_cause_wr = bus.stb & bus.we &  bus.addr;
    assign w_sw_req   = w_scr_wr & bus.data_in[0];
    assign w_req      = w_sw_req | (|rst_req);
    assign w_start    = (r_state == IDLE) & w_req;
    assign w_busy     = (r_state != IDLE);
    assign sysrst     = r_sysrst;
    assign bus.ack    = bus.stb;

    // Next-state logic; the hold counter loads RST_HOLD on entry and leaves at 1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = CW'(RST_HOLD);
                end
            end
            HOLD: begin
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            SETTLE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, counter and registered sysrst (high exactly while in HOLD).
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef SYSCTRL_RST_ON_POR_EN
            r_state  <= HOLD;
            r_cnt    <= CW'(RST_HOLD);
            r_sysrst <= 1'b1;
`else
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_sysrst <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sysrst <= (w_state_nxt == HOLD);
        end
    end

    // SCR storage: survives sequences, written even while busy.
    always_ff @(posedge clk) begin
        if (rst)           r_scr <= '0;
        else if (w_scr_wr) r_scr <= bus.data_in[DATA_WIDTH-1:1];
    end

    // CAUSE: a sequence start overrides a same-cycle W1C write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause <= '0;
            r_por   <= 1'b1;
            r_count <= '0;
        end else if (w_start) begin
            r_cause <= {rst_req, w_sw_req};
            r_por   <= 1'b0;
            if (r_count != 8'hFF) r_count <= r_count + 8'd1;
        end else if (w_cause_wr) begin
            r_cause <= r_cause & ~bus.data_in[NUM_CAUSES:0];
            if (bus.data_in[15]) r_por   <= 1'b0;
            if (bus.data_in[16]) r_count <= '0;
        end
    end

    // Read data assembly and combinational read mux.
    always_comb begin
        w_scr_rd                   = '0;
        w_scr_rd[DATA_WIDTH-1:1]   = r_scr;
        w_scr_rd[0]                = w_busy;
        w_cause_rd                 = '0;
        w_cause_rd[NUM_CAUSES:0]   = r_cause;
        w_cause_rd[15]             = r_por;
        w_cause_rd[23:16]          = r_count;
        bus.data_out               = '0;
        if (bus.stb && !bus.we)
            bus.data_out = bus.addr ? w_cause_rd : w_scr_rd;
    end
endmodule

// File: tb/tb_sysctrl_multi.sv
// tb_sysctrl_multi: directed tests for sysctrl_multi (DATA_WIDTH=16,
// NUM_CAUSES=2, RST_HOLD=4). Inputs change 1 time unit after the rising edge.
module tb_sysctrl_multi;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rst_req = 2'b00;
    logic       sysrst;
    int         n_tests = 0;
    int         n_fail  = 0;

    sysctrl_multi_if bus();

    sysctrl_multi #(.DATA_WIDTH(16), .NUM_CAUSES(2), .RST_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .bus(bus), .rst_req(rst_req), .sysrst(sysrst)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic a, input logic [31:0] d);
        bus.stb = 1'b1; bus.we = 1'b1; bus.addr = a; bus.data_in = d;
        tick();
        bus.stb = 1'b0; bus.we = 1'b0; bus.data_in = '0;
    endtask

    task automatic bus_read(input logic a, output logic [31:0] d);
        bus.stb = 1'b1; bus.we = 1'b0; bus.addr = a;
        #1;
        d = bus.data_out;
        bus.stb = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
`ifdef SYSCTRL_RST_ON_POR_EN
        for (int i = 0; i < HOLD; i++) begin
            n_tests++;
            if (sysrst !== 1'b1) begin n_fail++; $display("FAIL por_hold[%0d] got %b want 1", i, sysrst); end
            tick();
        end
        n_tests++;
        if (sysrst !== 1'b0) begin n_fail++; $display("FAIL por_end got %b want 0", sysrst); end
        tick();
        bus_read(1'b1, d);
        n_tests++;
        if (d !== 32'h0000_8000) begin n_fail++; $display("FAIL por_cause got %h want 00008000", d); end
`else
        n_tests++;
        if (sysrst !== 1'b0) begin n_fail++; $display("FAIL rst_sysrst got %b want 0", sysrst); end
        bus_read(1'b1, d);
        n_tests++;
        if (d !== 32'h0000_8000) begin n_fail++; $display("FAIL rst_cause got %h want 00008000", d); end
        bus_read(1'b0, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rst_scr got %h want 0", d); end
        n_tests++;
        if (bus.data_out !== 32'h0) begin n_fail++; $display("FAIL rst_idle_dout got %h want 0", bus.data_out); end
`endif
        bus.stb = 1'b1; #1;
        n_tests++;
        if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL ack_follow got %b want 1", bus.ack); end
        bus.stb = 1'b0; #1;
    endtask

    task automatic test_sw_reset();
        logic [31:0] d;
        bus_write(1'b0, 32'h0000_00A5);       // now cycle N+1
        for (int i = 0; i < HOLD; i++) begin
            n_tests++;
            if (sysrst !== 1'b1) begin n_fail++; $display("FAIL sw_hold[%0d] got %b want 1", i, sysrst); end
            if (i == 1) begin
                bus_read(1'b0, d);
                n_tests++;
                if (d !== 32'h0000_00A5) begin n_fail++; $display("FAIL sw_busy got %h want 000000a5", d); end
            end
            tick();
        end
        n_tests++;                            // cycle N+5, SETTLE
        if (sysrst !== 1'b0) begin n_fail++; $display("FAIL sw_settle got %b want 0", sysrst); end
        tick();                               // N+6, IDLE
        bus_read(1'b0, d);
        n_tests++;
        if (d !== 32'h0000_00A4) begin n_fail++; $display("FAIL sw_scr got %h want 000000a4", d); end
        bus_read(1'b1, d);
        n_tests++;
        if (d !== 32'h0001_0001) begin n_fail++; $display("FAIL sw_cause got %h want 00010001", d); end
    endtask

    task automatic test_concurrent();
        logic [31:0] d;
        rst_req = 2'b10;
        bus_write(1'b0, 32'h0000_00A5);       // cycle N1
        rst_req = 2'b01;                      // pulse in HOLD: ignored
        tick();
        rst_req = 2'b00;
        bus_write(1'b0, 32'h0000_1235);       // bit 0 ignored, storage written
        tick(); tick();                       // now N+5 (SETTLE)
        n_tests++;
        if (sysrst !== 1'b0) begin n_fail++; $display("FAIL cc_settle got %b want 0", sysrst); end
        tick(); tick();                       // N+7: would be HOLD if re-triggered
        n_tests++;
        if (sysrst !== 1'b0) begin n_fail++; $display("FAIL cc_no_retrig got %b want 0", sysrst); end
        bus_read(1'b1, d);
        n_tests++;
        if (d !== 32'h0002_0005) begin n_fail++; $display("FAIL cc_cause got %h want 00020005", d); end
        bus_read(1'b0, d);
        n_tests++;
        if (d !== 32'h0000_1234) begin n_fail++; $display("FAIL cc_scr got %h want 00001234", d); end
    endtask

    task automatic test_count_clear();
        logic [31:0] d;
        rst_req = 2'b01;                      // back-to-back sequences
        for (int i = 0; i < 300 * (HOLD + 2); i++) tick();
        rst_req = 2'b00;                      // 300 sequences done, back in IDLE
        bus_read(1'b1, d);
        n_tests++;
        if (d !== 32'h00FF_0002) begin n_fail++; $display("FAIL cnt_sat got %h want 00ff0002", d); end
        bus_read(1'b0, d);
        n_tests++;
        if (d[0] !== 1'b0) begin n_fail++; $display("FAIL cnt_idle busy got %b want 0", d[0]); end
        bus_write(1'b1, 32'h0001_FFFF);
        bus_read(1'b1, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL cnt_clear got %h want 0", d); end
    endtask

    task automatic test_rst_mid_seq();
        logic [31:0] d;
        rst_req = 2'b10;
        tick();                               // HOLD cycle 1
        rst_req = 2'b00;
        tick();                               // HOLD cycle 2
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (sysrst !== 1'b0) begin n_fail++; $display("FAIL mid_sysrst got %b want 0", sysrst); end
        bus_read(1'b0, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL mid_scr got %h want 0", d); end
        bus_read(1'b1, d);
        n_tests++;
        if (d !== 32'h0000_8000) begin n_fail++; $display("FAIL mid_cause got %h want 00008000", d); end
    endtask

    initial begin
        bus.stb = 1'b0; bus.we = 1'b0; bus.addr = 1'b0; bus.data_in = '0;
        #1;
        test_reset();
`ifndef SYSCTRL_RST_ON_POR_EN
        test_sw_reset();
        test_concurrent();
        test_count_clear();
        test_rst_mid_seq();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
